// File: rtl/array_mul_pkg.sv
// -----------------------------------------------------------------------------
// array_mul_pkg
//   Shared constants for the carry-save array multiplier.
//   default_k : operand width used when the instantiating code does not
//               override the multiplier's k parameter.
//   min_k     : smallest operand width the array topology supports (the final
//               ripple row needs at least two columns).
// -----------------------------------------------------------------------------
package array_mul_pkg;

  localparam int unsigned default_k = 8;
  localparam int unsigned min_k     = 2;

endpackage : array_mul_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full-adder cell, the only arithmetic primitive of the array
//   multiplier. Purely combinational.
//
// Ports
//   a, b, cin : input  addend bits and carry in
//   sum       : output a ^ b ^ cin
//   cout      : output majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/array_mul.sv
// -----------------------------------------------------------------------------
// array_mul
//   Unsigned k x k array multiplier: an AND grid of partial products reduced
//   by k-1 carry-save rows of full adders, resolved by a k-bit ripple-carry
//   row, with the full 2k-bit product registered once. Latency is one cycle,
//   throughput one product per cycle, no handshake.
//
// Parameters
//   k        : operand width in bits (k >= 2)
//
// Ports
//   clk      : input  clock, rising edge active
//   rst_n    : input  asynchronous active-low reset, clears result
//   mul_cand : input  [k-1:0]   multiplicand, unsigned
//   mul_ier  : input  [k-1:0]   multiplier, unsigned
//   result   : output [2k-1:0]  registered product mul_cand * mul_ier
// -----------------------------------------------------------------------------
module array_mul
  import array_mul_pkg::*;
#(
  parameter int unsigned k = default_k
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [k-1:0]   mul_cand,
  input  logic [k-1:0]   mul_ier,
  output logic [2*k-1:0] result
);

  // ---------------------------------------------------------------------------
  // Partial products: pp[i][j] = mul_cand[j] & mul_ier[i], weight i+j.
  // ---------------------------------------------------------------------------
  logic [k-1:0][k-1:0] pp;

  for (genvar i = 0; i < k; i++) begin : g_pp_row
    assign pp[i] = mul_cand & {k{mul_ier[i]}};
  end

  // ---------------------------------------------------------------------------
  // Carry-save rows.
  //   row_sum[i][j]   has weight i+j
  //   row_carry[i][j] has weight i+j+1
  // Row i column j adds pp[i][j], the previous row's sum one column to the
  // left (row_sum[i-1][j+1]) and the previous row's carry of the same column;
  // all three carry weight i+j. sum_up[i] is row i's sum shifted down one
  // column, with a zero entering the top where no previous sum exists.
  // ---------------------------------------------------------------------------
  logic [k-1:0][k-1:0] row_sum;
  logic [k-1:0][k-1:0] row_carry;
  logic [k-1:0][k-1:0] sum_up;

  // Row 0 is the first partial product passed straight through.
  assign row_sum[0]   = pp[0];
  assign row_carry[0] = '0;

  for (genvar i = 0; i < k; i++) begin : g_sum_up
    assign sum_up[i] = {1'b0, row_sum[i][k-1:1]};
  end

  for (genvar i = 1; i < k; i++) begin : g_csa_row
    for (genvar j = 0; j < k; j++) begin : g_csa_col
      full_adder u_fa (
        .a    (pp[i][j]),
        .b    (sum_up[i-1][j]),
        .cin  (row_carry[i-1][j]),
        .sum  (row_sum[i][j]),
        .cout (row_carry[i][j])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Low product bits: bit i is the column-0 sum of row i; nothing else ever
  // adds into that weight once row i has produced it.
  // ---------------------------------------------------------------------------
  logic [k-1:0] prod_lo;

  for (genvar i = 0; i < k; i++) begin : g_lo
    assign prod_lo[i] = row_sum[i][0];
  end

  // ---------------------------------------------------------------------------
  // Final ripple-carry row: resolves the last row's shifted sum and carry
  // vectors into product bits k .. 2k-1.
  // ---------------------------------------------------------------------------
  logic [k:0]   rip_c;
  logic [k-1:0] rip_sum;

  assign rip_c[0] = 1'b0;

  for (genvar j = 0; j < k; j++) begin : g_ripple
    full_adder u_fa (
      .a    (sum_up[k-1][j]),
      .b    (row_carry[k-1][j]),
      .cin  (rip_c[j]),
      .sum  (rip_sum[j]),
      .cout (rip_c[j+1])
    );
  end

  // The top ripple column only sees the last carry and the ripple carry, and
  // the two are never both set because the product always fits in 2k bits.
  // So sum | cout equals sum there, and folding cout in keeps the cell's
  // output consumed without a separate carry-out path.
  logic [2*k-1:0] product;

  assign product = {rip_sum[k-1] | rip_c[k], rip_sum[k-2:0], prod_lo};

  // ---------------------------------------------------------------------------
  // Output register.
  // ---------------------------------------------------------------------------
  // NOTE: state is written with non-blocking assignments so every register in
  // the design samples its inputs from the same pre-edge values; blocking
  // assignments here would make results depend on process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else begin
      result <= product;
    end
  end

endmodule : array_mul

// File: tb/tb_array_mul.sv
// -----------------------------------------------------------------------------
// tb_array_mul
//   Self-checking bench for array_mul at k = 8 (directed, back-to-back, reset
//   and random stimulus), k = 4 (every operand pair) and k = 16 (random
//   pairs). Expected products come from plain integer multiplication of the
//   operands applied one clock earlier.
// -----------------------------------------------------------------------------
module tb_array_mul;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic [7:0]  a8,  b8;
  logic [15:0] r8;
  logic [3:0]  a4,  b4;
  logic [7:0]  r4;
  logic [15:0] a16, b16;
  logic [31:0] r16;

  array_mul #(.k(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mul_cand (a8),
    .mul_ier  (b8),
    .result   (r8)
  );

  array_mul #(.k(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mul_cand (a4),
    .mul_ier  (b4),
    .result   (r4)
  );

  array_mul #(.k(16)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mul_cand (a16),
    .mul_ier  (b16),
    .result   (r16)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input longint unsigned a, input longint unsigned b);
    return a * b;
  endfunction

  // Directed k = 8 operand pairs.
  int unsigned dir_a [7] = '{1, 15, 255,   0, 170, 240, 255};
  int unsigned dir_b [7] = '{1,  1,   1, 200,  85,  15, 255};

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [63:0] prev_exp;

    // ---------------- reset with all-ones operands ----------------
    rst_n = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF;
    a4 = '0;    b4 = '0;
    a16 = '0;   b16 = '0;
    #1;
    check("rst_immediate", r8, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_hold", r8, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release", r8, 65025);

    // ---------------- directed, one product at a time ----------------
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a8 = 8'(dir_a[i]); b8 = 8'(dir_b[i]);
      @(posedge clk); #1;
      check("directed", r8, ref_mul(dir_a[i], dir_b[i]));
    end

    // ---------------- back-to-back, new operands every cycle ----------------
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i > 0) check("b2b", r8, prev_exp);
      a8 = 8'(dir_a[i]); b8 = 8'(dir_b[i]);
      prev_exp = ref_mul(dir_a[i], dir_b[i]);
    end
    for (int i = 0; i < 200; i++) begin
      int unsigned ra, rb;
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      @(negedge clk);
      check("rand8", r8, prev_exp);
      a8 = 8'(ra); b8 = 8'(rb);
      prev_exp = ref_mul(ra, rb);
    end
    @(negedge clk);
    check("rand8_last", r8, prev_exp);

    // ---------------- reset pulse inside a cycle ----------------
    a8 = 8'd170; b8 = 8'd85;
    @(posedge clk); #2;
    check("pre_mid_rst", r8, 14450);
    rst_n = 1'b0;
    #1;
    check("mid_rst_immediate", r8, 0);
    a8 = 8'd240; b8 = 8'd15;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_released_no_edge", r8, 0);
    @(posedge clk); #1;
    check("post_mid_rst", r8, 3600);

    // ---------------- k = 4, every operand pair ----------------
    @(negedge clk);
    a4 = '0; b4 = '0;
    prev_exp = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        @(negedge clk);
        check("k4_exhaustive", r4, prev_exp);
        a4 = 4'(x); b4 = 4'(y);
        prev_exp = ref_mul(longint'(x), longint'(y));
      end
    end
    @(negedge clk);
    check("k4_last", r4, prev_exp);

    // ---------------- k = 16, random pairs ----------------
    a16 = 16'hFFFF; b16 = 16'hFFFF;
    prev_exp = ref_mul(65535, 65535);
    for (int i = 0; i < 10000; i++) begin
      int unsigned ra, rb;
      ra = $urandom_range(0, 65535);
      rb = $urandom_range(0, 65535);
      @(negedge clk);
      check("k16_random", r16, prev_exp);
      a16 = 16'(ra); b16 = 16'(rb);
      prev_exp = ref_mul(ra, rb);
    end
    @(negedge clk);
    check("k16_last", r16, prev_exp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_array_mul
